// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer: the FSM state encoding doubles as the occupancy count.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle between a producer, the skid buffer and a consumer.
interface skid_buffer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  flush_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] s_dat_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_dat_o;
  logic [1:0]            occ_o;

  modport slave (
    input  flush_i, s_valid_i, s_dat_i, m_ready_i,
    output s_ready_o, m_valid_o, m_dat_o, occ_o
  );

  modport master (
    output flush_i, s_valid_i, s_dat_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_dat_o, occ_o
  );

endinterface

// File: rtl/skid_buffer_cells.sv
// Common register cells: async active-low reset to zero (dffr), to ones (dffrh),
// and to zero with a load enable (dffer).
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= '0;
    else          q_o <= d_i;
  end

endmodule

module dffrh #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= '1;
    else          q_o <= d_i;
  end

endmodule

module dffer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline stage with every handshake output registered,
// sustaining one transfer per cycle while cutting both forward and backward paths.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic          clk_i,
  input logic          rst_n_i,
  skid_buffer_if.slave bus
);

  logic [1:0]            r_state_q;
  logic                  r_rdy;
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;

  skid_state_e           w_state;
  skid_state_e           w_state_nxt;
  logic                  w_in;
  logic                  w_out;
  logic                  w_main_en;
  logic                  w_main_from_skid;
  logic                  w_skid_en;
  logic                  w_rdy_nxt;
  logic                  w_vld_nxt;
  logic [DATA_WIDTH-1:0] w_main_d;

  assign w_state = skid_state_e'(r_state_q);
  assign w_in    = bus.s_valid_i & r_rdy;
  assign w_out   = r_vld & bus.m_ready_i;

  // Flush overrides every transition and suppresses loads so the flushed beat is dropped.
  always_comb begin
    w_state_nxt      = w_state;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;
    case (w_state)
      SKID_EMPTY: begin
        if (w_in) begin
          w_state_nxt = SKID_BUSY;
          w_main_en   = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (w_in && w_out) begin
          w_main_en = 1'b1;
        end else if (w_in) begin
          w_state_nxt = SKID_FULL;
          w_skid_en   = 1'b1;
        end else if (w_out) begin
          w_state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (w_out) begin
          w_state_nxt      = SKID_BUSY;
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = SKID_EMPTY;
    endcase
    if (bus.flush_i) begin
      w_state_nxt = SKID_EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
    w_rdy_nxt = (w_state_nxt != SKID_FULL);
    w_vld_nxt = (w_state_nxt != SKID_EMPTY);
    w_main_d  = w_main_from_skid ? r_skid : bus.s_dat_i;
  end

  dffr  #(.W(2))          u_state (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(w_state_nxt), .q_o(r_state_q));
  dffrh #(.W(1))          u_rdy   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(w_rdy_nxt),   .q_o(r_rdy));
  dffr  #(.W(1))          u_vld   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(w_vld_nxt),   .q_o(r_vld));
  dffer #(.W(DATA_WIDTH)) u_main  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(w_main_en),
                                   .d_i(w_main_d), .q_o(r_main));
  dffer #(.W(DATA_WIDTH)) u_skid  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(w_skid_en),
                                   .d_i(bus.s_dat_i), .q_o(r_skid));

  assign bus.s_ready_o = r_rdy;
  assign bus.m_valid_o = r_vld;
  assign bus.m_dat_o   = r_main;
  assign bus.occ_o     = r_state_q;

`ifndef SV_ASSRT_DISABLE
  a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !$isunknown({bus.s_valid_i, bus.m_ready_i, bus.flush_i}));

  a_upstream_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (bus.s_valid_i && !bus.s_ready_o) |=> (bus.s_valid_i && $stable(bus.s_dat_i)));

  a_occ_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    bus.occ_o != 2'd3);
`endif

endmodule
